// File: rtl/lsu_handshake.sv
// Load/store unit: turns the core's single-cycle memory controls into a req/ready
// transaction, stalling the core until the access completes, errors, or times out.
module lsu_handshake #(
    parameter int WORD_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [2:0]            core_size,
    input  logic [WORD_WIDTH-1:0] core_addr,
    input  logic [WORD_WIDTH-1:0] core_wd,
    output logic [WORD_WIDTH-1:0] core_rd,
    output logic                  core_stall,
    output logic                  core_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [WORD_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wd,
    input  logic [WORD_WIDTH-1:0] mem_rd,
    input  logic                  mem_ready
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t                r_state, w_state_next;
    logic                  r_mem_req, w_mem_req_next;
    logic                  r_mem_we, w_mem_we_next;
    logic [3:0]            r_mem_be, w_mem_be_next;
    logic [WORD_WIDTH-1:0] r_mem_addr, w_mem_addr_next;
    logic [WORD_WIDTH-1:0] r_mem_wd, w_mem_wd_next;
    logic [WORD_WIDTH-1:0] r_core_rd, w_core_rd_next;
    logic                  r_core_err, w_core_err_next;
    logic [2:0]            r_size, w_size_next;
    logic [1:0]            r_a, w_a_next;
    logic [31:0]           r_cnt, w_cnt_next;

    logic                  w_bad;
    logic [3:0]            w_be;
    logic [WORD_WIDTH-1:0] w_wd;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [WORD_WIDTH-1:0] w_load;

    // Illegal size, misalignment, or a store with an unsigned (load-only) size.
    always_comb begin
        w_bad = 1'b0;
        case (core_size)
            3'b000, 3'b100: w_bad = 1'b0;
            3'b001, 3'b101: w_bad = core_addr[0];
            3'b010:         w_bad = |core_addr[1:0];
            default:        w_bad = 1'b1;
        endcase
        if (core_we && core_size[2])
            w_bad = 1'b1;
    end

    assign core_stall = core_req & (r_state != S_DONE) & ~w_bad;

    always_comb begin
        case (core_size[1:0])
            2'b00:   w_be = 4'b0001 << core_addr[1:0];
            2'b01:   w_be = 4'b0011 << core_addr[1:0];
            default: w_be = 4'b1111;
        endcase
        case (core_size[1:0])
            2'b00:   w_wd = {4{core_wd[7:0]}};
            2'b01:   w_wd = {2{core_wd[15:0]}};
            default: w_wd = core_wd;
        endcase
    end

    // Lane extraction uses the offset captured at issue, not the live address.
    assign w_byte = mem_rd[{r_a, 3'b000} +: 8];
    assign w_half = mem_rd[{r_a[1], 4'b0000} +: 16];

    always_comb begin
        case (r_size)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'd0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = mem_rd;
        endcase
    end

    always_comb begin
        w_state_next    = r_state;
        w_mem_req_next  = r_mem_req;
        w_mem_we_next   = r_mem_we;
        w_mem_be_next   = r_mem_be;
        w_mem_addr_next = r_mem_addr;
        w_mem_wd_next   = r_mem_wd;
        w_core_rd_next  = r_core_rd;
        w_core_err_next = 1'b0;
        w_size_next     = r_size;
        w_a_next        = r_a;
        w_cnt_next      = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (core_req && w_bad) begin
                    w_core_err_next = 1'b1;
                    w_core_rd_next  = '0;
                end else if (core_req) begin
                    w_mem_req_next  = 1'b1;
                    w_mem_we_next   = core_we;
                    w_mem_be_next   = w_be;
                    w_mem_addr_next = {core_addr[WORD_WIDTH-1:2], 2'b00};
                    w_mem_wd_next   = w_wd;
                    w_size_next     = core_size;
                    w_a_next        = core_addr[1:0];
                    w_state_next    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_ready) begin
                    w_mem_req_next = 1'b0;
                    w_core_rd_next = r_mem_we ? '0 : w_load;
                    w_state_next   = S_DONE;
                end else begin
                    w_cnt_next = r_cnt + 32'd1;
                    if (TIMEOUT_CYCLES != 0 && r_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        w_mem_req_next  = 1'b0;
                        w_core_err_next = 1'b1;
                        w_core_rd_next  = '0;
                        w_state_next    = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_cnt_next   = '0;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_be   <= 4'd0;
            r_mem_addr <= '0;
            r_mem_wd   <= '0;
            r_core_rd  <= '0;
            r_core_err <= 1'b0;
            r_size     <= 3'd0;
            r_a        <= 2'd0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_mem_req  <= w_mem_req_next;
            r_mem_we   <= w_mem_we_next;
            r_mem_be   <= w_mem_be_next;
            r_mem_addr <= w_mem_addr_next;
            r_mem_wd   <= w_mem_wd_next;
            r_core_rd  <= w_core_rd_next;
            r_core_err <= w_core_err_next;
            r_size     <= w_size_next;
            r_a        <= w_a_next;
            r_cnt      <= w_cnt_next;
        end
    end

    assign mem_req  = r_mem_req;
    assign mem_we   = r_mem_we;
    assign mem_be   = r_mem_be;
    assign mem_addr = r_mem_addr;
    assign mem_wd   = r_mem_wd;
    assign core_rd  = r_core_rd;
    assign core_err = r_core_err;

endmodule

// File: tb/tb_lsu_handshake.sv
// Bench for lsu_handshake: acts as core and variable-latency memory, checking every
// transaction against an arithmetic model of the load/store rules.
module tb_lsu_handshake;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we;
    logic [2:0]  core_size;
    logic [31:0] core_addr, core_wd, core_rd;
    logic        core_stall, core_err;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_handshake #(.WORD_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_size(core_size),
        .core_addr(core_addr), .core_wd(core_wd), .core_rd(core_rd),
        .core_stall(core_stall), .core_err(core_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .mem_ready(mem_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: access width in bytes, legality, lanes and extension.
    function automatic int nbytes(input logic [2:0] sz);
        return 1 << sz[1:0];
    endfunction

    function automatic bit is_bad(input logic we, input logic [2:0] sz, input logic [31:0] addr);
        int off;
        off = int'(addr[1:0]);
        if (!(sz inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        if (we && sz >= 3'd4) return 1'b1;
        return (off % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] sz, input logic [31:0] addr);
        int v;
        v = ((1 << nbytes(sz)) - 1) << int'(addr[1:0]);
        return 4'(v);
    endfunction

    function automatic logic [31:0] exp_wd(input logic [2:0] sz, input logic [31:0] wd);
        if (nbytes(sz) == 1) return {24'd0, wd[7:0]} * 32'h01010101;
        if (nbytes(sz) == 2) return {16'd0, wd[15:0]} * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] sz, input logic [31:0] addr,
                                             input logic [31:0] word);
        logic [31:0] v, mask;
        int n;
        n = nbytes(sz);
        if (n == 4) return word;
        v    = word >> (8 * int'(addr[1:0]));
        mask = (n == 1) ? 32'h000000FF : 32'h0000FFFF;
        v    = v & mask;
        if (!sz[2] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // One core memory instruction; memory answers after lat WAIT cycles (or never).
    task automatic txn(input string nm, input logic we, input logic [2:0] sz,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rdata, input int lat);
        bit bad, timed_out;
        bad = is_bad(we, sz, addr);
        core_req = 1'b1; core_we = we; core_size = sz; core_addr = addr; core_wd = wd;
        mem_ready = 1'b0;
        #1;
        chk({nm, " stall_issue"}, core_stall, !bad);
        tick();
        if (bad) begin
            chk({nm, " err_pulse"}, core_err, 1'b1);
            chk({nm, " no_req"}, mem_req, 1'b0);
            chk({nm, " rd_zero"}, core_rd, 32'd0);
            chk({nm, " no_stall"}, core_stall, 1'b0);
            core_req = 1'b0;
            tick();
            chk({nm, " err_clear"}, core_err, 1'b0);
            chk({nm, " no_req2"}, mem_req, 1'b0);
            $display("txn %s we=%0d size=%0d addr=%h -> rejected", nm, we, sz, addr);
            return;
        end
        chk({nm, " mem_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
        chk({nm, " mem_be"}, mem_be, exp_be(sz, addr));
        chk({nm, " mem_we"}, mem_we, we);
        if (we) chk({nm, " mem_wd"}, mem_wd, exp_wd(sz, wd));
        timed_out = 1'b0;
        for (int w = 0; ; w++) begin
            chk({nm, " wait_req"}, mem_req, 1'b1);
            chk({nm, " wait_stall"}, core_stall, 1'b1);
            mem_ready = (w == lat);
            mem_rd    = (w == lat) ? rdata : $urandom;
            tick();
            if (w == lat) break;
            if (w == TO - 1) begin timed_out = 1'b1; break; end
        end
        mem_ready = 1'b0;
        chk({nm, " done_req"}, mem_req, 1'b0);
        chk({nm, " done_stall"}, core_stall, 1'b0);
        chk({nm, " done_err"}, core_err, timed_out);
        chk({nm, " done_rd"}, core_rd, (timed_out || we) ? 32'd0 : exp_load(sz, addr, rdata));
        tick();
        chk({nm, " idle_req"}, mem_req, 1'b0);
        chk({nm, " idle_err"}, core_err, 1'b0);
        $display("txn %s we=%0d size=%0d addr=%h lat=%0d timeout=%0d rd=%h",
                 nm, we, sz, addr, lat, timed_out, core_rd);
    endtask

    initial begin
        rst = 1'b1; core_req = 1'b0; core_we = 1'b0; core_size = 3'd0;
        core_addr = 32'd0; core_wd = 32'd0; mem_rd = 32'd0; mem_ready = 1'b0;
        repeat (3) tick();
        chk("rst mem_req", mem_req, 1'b0);
        chk("rst mem_we", mem_we, 1'b0);
        chk("rst mem_be", mem_be, 4'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_wd", mem_wd, 32'd0);
        chk("rst core_rd", core_rd, 32'd0);
        chk("rst core_err", core_err, 1'b0);
        chk("rst stall", core_stall, 1'b0);
        rst = 1'b0;
        tick();

        txn("LW_10", 1'b0, 3'b010, 32'h10, 32'd0, 32'hDEADBEEF, 0);
        txn("LB_13", 1'b0, 3'b000, 32'h13, 32'd0, 32'h80FF1234, 0);

        // Reset lands on the second WAIT cycle; a late ready must be ignored.
        core_req = 1'b1; core_we = 1'b0; core_size = 3'b010; core_addr = 32'h80;
        tick();
        chk("rstmid wait1_req", mem_req, 1'b1);
        tick();
        chk("rstmid wait2_req", mem_req, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0; core_req = 1'b0; mem_ready = 1'b1; mem_rd = 32'h12345678;
        chk("rstmid req_drop", mem_req, 1'b0);
        chk("rstmid rd_zero", core_rd, 32'd0);
        tick();
        mem_ready = 1'b0;
        chk("rstmid late_req", mem_req, 1'b0);
        chk("rstmid late_rd", core_rd, 32'd0);
        chk("rstmid late_err", core_err, 1'b0);
        $display("txn RSTMID reset during WAIT -> req=%0d rd=%h", mem_req, core_rd);

        txn("LBU_13", 1'b0, 3'b100, 32'h13, 32'd0, 32'h80FF1234, 2);
        txn("SH_22", 1'b1, 3'b001, 32'h22, 32'h0000ABCD, 32'd0, 1);
        txn("LW_05", 1'b0, 3'b010, 32'h05, 32'd0, 32'h0, 0);
        txn("LW_TO", 1'b0, 3'b010, 32'h40, 32'd0, 32'h0, 100);
        txn("LH_22", 1'b0, 3'b001, 32'h22, 32'd0, 32'h8001_7FFF, 3);

        for (int i = 0; i < 60; i++) begin
            logic [2:0] sz;
            sz = 3'($urandom_range(0, 7));
            txn($sformatf("RND%0d", i), 1'($urandom_range(0, 1)), sz, $urandom,
                $urandom, $urandom, $urandom_range(0, 5));
        end

        core_req = 1'b0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
